// File: rtl/fetch_queue_unit_pkg.sv
// Shared defaults and helpers for the instruction-fetch queue.
// Default address/instruction widths, queue depth and reset PC live here.
// Pointer-width helper keeps the top and the FIFO sized consistently.
package fetch_queue_unit_pkg;

  localparam int          FQ_ADDR_W   = 32;
  localparam int          FQ_INST_W   = 32;
  localparam int          FQ_DEPTH    = 4;
  localparam logic [31:0] FQ_RESET_PC = 32'h0000_0000;
  localparam int          FQ_PC_STEP  = 4;

  // Pointer width for a power-of-two queue; counters are one bit wider.
  function automatic int fq_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_sync_fifo.sv
// Synchronous FIFO holding {pc, inst} entries for the fetch queue.
// Latency: a push is visible at the head one cycle later; the head is driven straight from storage.
// Backpressure: clear wins over push/pop; pop on empty is ignored; the caller never pushes into a full queue.
module fetch_sync_fifo
  import fetch_queue_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       clear,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [fq_ptr_w(DEPTH):0]   count
);

  localparam int PW = fq_ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push & ~clear;
  assign do_pop   = pop & ~empty & ~clear;
  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  // An empty queue presents zeros so decode never sees stale storage.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Sequential instruction fetch front end: credit-limited requests, in-order responses, DEPTH-entry queue to decode.
// Latency: request handshake in cycle N, response in N+1, dec_valid in N+2 (registered queue, no bypass).
// Backpressure: requests stop when queued + outstanding reaches DEPTH; dec_ready low holds the head. Optional perf counters under FETCHQ_PERF_EN.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int                ADDR_W   = FQ_ADDR_W,
  parameter int                INST_W   = FQ_INST_W,
  parameter int                DEPTH    = FQ_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FQ_RESET_PC)
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [INST_W-1:0] dec_inst,
  output logic [ADDR_W-1:0] dec_pc
`ifdef FETCHQ_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int                PW      = fq_ptr_w(DEPTH);
  localparam int                CW      = PW + 1;
  localparam logic [CW:0]       DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(FQ_PC_STEP);

  logic [ADDR_W-1:0]        fetch_pc;
  logic [ADDR_W-1:0]        resp_pc;
  logic [CW-1:0]            outstanding;
  logic [CW-1:0]            drop_cnt;
  logic [CW-1:0]            q_count;
  logic [CW:0]              in_use;
  logic                     q_full;
  logic                     q_empty;
  logic                     q_push;
  logic                     q_pop;
  logic                     req_fire;
  logic [ADDR_W+INST_W-1:0] q_head;

  // Credit: every issued request owns a queue slot until its response lands or is discarded.
  assign in_use         = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req_valid = resetN & ~redirect_valid & (in_use < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign q_push    = imem_rsp_valid & (drop_cnt == '0) & ~redirect_valid;
  assign q_pop     = dec_valid & dec_ready & ~redirect_valid;
  assign dec_valid = ~q_empty;
  assign {dec_pc, dec_inst} = q_head;

  fetch_sync_fifo #(
    .WIDTH (ADDR_W + INST_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetN    (resetN),
    .push      (q_push),
    .push_data ({resp_pc, imem_rsp_data}),
    .pop       (q_pop),
    .clear     (redirect_valid),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // PC, credit and drop bookkeeping; a redirect restarts both PCs and marks everything in flight as stale.
  // drop_cnt is always a subset of outstanding, so after a redirect exactly the remaining in-flight responses are stale.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_addr;
      resp_pc     <= redirect_addr;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      drop_cnt    <= outstanding - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid) begin
        if (drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        else                resp_pc  <= resp_pc + PC_STEP;
      end
    end
  end

  // The credit rule must keep pushes away from a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetN) !(q_push && q_full));

`ifdef FETCHQ_PERF_EN
  // Saturating counts of decode stall cycles and redirects.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (dec_valid && !dec_ready && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect_valid && (perf_flush_cnt != '1))          perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: in-order memory model with per-request latency,
// an epoch-based reference of what decode must receive, and directed scenarios with literal expectations.
// Define FETCHQ_PERF_EN to also cover the performance counters.
module tb_fetch_queue_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        resetN;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
`ifdef FETCHQ_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  fetch_queue_unit dut (
    .clk            (clk),
    .resetN         (resetN),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc)
`ifdef FETCHQ_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; int epoch; int due;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
  typedef struct {logic [31:0] pc; logic [31:0] inst; int cyc;} pop_t;

  req_t        pend[$];
  ent_t        mq[$];
  pop_t        popped[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  int          epoch = 0;
  int          outst = 0;
  int          n_req = 0;
  int          n_pop = 0;
  int          n_drop = 0;
  int          first_req_cyc = -1;
  logic [31:0] first_req_addr = 32'hFFFF_FFFF;
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] rsp_addr = 32'h0;
  int          rsp_epoch = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_pop(input string name, input int idx, input logic [31:0] pc, input int c);
    if (popped.size() > idx) begin
      chk({name, "_pc"}, popped[idx].pc, pc);
      chk({name, "_inst"}, popped[idx].inst, mem_data(pc));
      if (c >= 0) chk({name, "_cyc"}, popped[idx].cyc, c);
    end else begin
      chk({name, "_present"}, popped.size(), idx + 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    tick();
    tick();
    popped.delete();
    n_req = 0;
    n_pop = 0;
    n_drop = 0;
    first_req_cyc = -1;
    first_req_addr = 32'hFFFF_FFFF;
    resetN = 1'b1;
  endtask

  task automatic pulse_redirect(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    tick();
    redirect_valid = 1'b0;
  endtask

  // Memory: returns responses in request order once each request's latency has elapsed.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (!resetN) begin
      imem_rsp_valid = 1'b0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      rsp_addr       = pend[0].addr;
      rsp_epoch      = pend[0].epoch;
      imem_rsp_data  = mem_data(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
    end
  end

  // Reference: decode must see, in order, the responses to requests issued since the last redirect/reset.
  always @(negedge clk) begin
    if (!resetN) begin
      mq.delete();
      pend.delete();
      outst    = 0;
      model_pc = RESET_PC;
      epoch    = epoch + 1;
    end else begin
      chk("dec_valid", dec_valid, mq.size() != 0);
      if (dec_valid && mq.size() != 0) begin
        chk("dec_pc", dec_pc, mq[0].pc);
        chk("dec_inst", dec_inst, mq[0].inst);
      end
      chk("req_valid", imem_req_valid, !redirect_valid && (mq.size() + outst < DEPTH));
      if (dec_valid && dec_ready && !redirect_valid && mq.size() != 0) begin
        popped.push_back('{dec_pc, dec_inst, cyc});
        void'(mq.pop_front());
        n_pop++;
      end
      if (imem_rsp_valid) begin
        outst--;
        if (!redirect_valid && rsp_epoch == epoch) mq.push_back('{rsp_addr, mem_data(rsp_addr)});
        else n_drop++;
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, model_pc);
        if (n_req == 0) begin
          first_req_cyc  = cyc;
          first_req_addr = imem_req_addr;
        end
        n_req++;
        pend.push_back('{imem_req_addr, epoch, cyc + lat});
        model_pc = model_pc + 32'd4;
        outst++;
      end
      if (redirect_valid) begin
        mq.delete();
        model_pc = redirect_addr;
        epoch    = epoch + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r;
    resetN         = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 32'h0;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    tick();
    tick();

    // Reset state
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_dec_inst", dec_inst, 0);
    chk("rst_dec_pc", dec_pc, 0);
`ifdef FETCHQ_PERF_EN
    chk("rst_perf_stall", perf_stall_cnt, 0);
    chk("rst_perf_flush", perf_flush_cnt, 0);
`endif

    // 1: streaming, 1-cycle memory latency
    lat = 1;
    do_reset();
    chk("t1_req_addr0", imem_req_addr, RESET_PC);
    repeat (8) tick();
    check_pop("t1_pop0", 0, 32'h0, first_req_cyc + 2);
    check_pop("t1_pop1", 1, 32'h4, first_req_cyc + 3);
    check_pop("t1_pop2", 2, 32'h8, first_req_cyc + 4);

    // 2: decode locked for 10 cycles, queue fills to DEPTH and fetch stops
    dec_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    chk("t2_req_count", n_req, DEPTH);
    chk("t2_req_valid", imem_req_valid, 0);
    chk("t2_dec_valid", dec_valid, 1);
    chk("t2_no_pop", n_pop, 0);
    dec_ready = 1'b1;
    r = cyc;
    repeat (6) tick();
    check_pop("t2_pop0", 0, 32'h0, r);
    check_pop("t2_pop1", 1, 32'h4, r + 1);
    check_pop("t2_pop2", 2, 32'h8, r + 2);
    check_pop("t2_pop3", 3, 32'hC, r + 3);

    // 3: redirect with three 5-cycle requests in flight
    lat = 5;
    do_reset();
    for (int k = 0; k < 20 && n_req < 3; k++) tick();
    imem_req_ready = 1'b0;
    chk("t3_req_count", n_req, 3);
    tick();
    n_drop = 0;
    popped.delete();
    pulse_redirect(32'h100);
    imem_req_ready = 1'b1;
    repeat (25) tick();
    chk("t3_dropped", n_drop, 3);
    check_pop("t3_first", 0, 32'h100, -1);
    check_pop("t3_second", 1, 32'h104, -1);

    // 4: redirect in the same cycle as a response
    lat = 2;
    do_reset();
    for (int k = 0; k < 20 && n_pop < 2; k++) tick();
    for (int k = 0; k < 20 && !imem_rsp_valid; k++) tick();
    chk("t4_rsp_seen", imem_rsp_valid, 1);
    popped.delete();
    pulse_redirect(32'h2000);
    repeat (12) tick();
    check_pop("t4_first", 0, 32'h2000, -1);
    check_pop("t4_second", 1, 32'h2004, -1);

    // 5: asynchronous reset while the queue is full
    lat = 1;
    dec_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    chk("t5_full_valid", dec_valid, 1);
    #1;
    resetN = 1'b0;
    #1;
    chk("t5_async_dec_valid", dec_valid, 0);
    chk("t5_async_req_valid", imem_req_valid, 0);
    chk("t5_async_dec_pc", dec_pc, 0);
    dec_ready = 1'b1;
    tick();
    do_reset();
    repeat (6) tick();
    chk("t5_restart_addr", first_req_addr, RESET_PC);
    check_pop("t5_first", 0, RESET_PC, -1);

`ifdef FETCHQ_PERF_EN
    // 6: 7 stall cycles and 2 redirects
    lat = 1;
    dec_ready = 1'b1;
    do_reset();
    chk("t6_perf_stall0", perf_stall_cnt, 0);
    for (int k = 0; k < 20 && !dec_valid; k++) tick();
    chk("t6_valid", dec_valid, 1);
    dec_ready = 1'b0;
    repeat (7) tick();
    dec_ready = 1'b1;
    repeat (5) tick();
    pulse_redirect(32'h400);
    repeat (10) tick();
    pulse_redirect(32'h800);
    repeat (10) tick();
    chk("t6_perf_stall", perf_stall_cnt, 7);
    chk("t6_perf_flush", perf_flush_cnt, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
